// File: rtl/reg_port_sequencer_pkg.sv
// Shared widths and FSM encoding for the register-port operand sequencer.
package reg_port_sequencer_pkg;
    localparam int DATA_W_DEF    = 16;
    localparam int SEL_W_DEF     = 3;
    localparam int OP_W_DEF      = 4;
    localparam int STALL_MAX_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        OUT    = 2'd3
    } seq_state_e;
endpackage

// File: rtl/reg_port_sequencer_if.sv
// Issue, writeback, register-bank and execute-handoff signals of the sequencer.
interface reg_port_sequencer_if
    import reg_port_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int OP_W   = OP_W_DEF
) ();
    logic              issue_valid;
    logic              issue_ready;
    logic [SEL_W-1:0]  issue_rs1;
    logic [SEL_W-1:0]  issue_rs2;
    logic [SEL_W-1:0]  issue_rd;
    logic [OP_W-1:0]   issue_op;

    logic              wb_valid;
    logic              wb_ready;
    logic [SEL_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic [SEL_W-1:0]  rb_sel;
    logic              rb_treg;
    logic              rb_lreg;
    logic [DATA_W-1:0] rb_in;
    logic [DATA_W-1:0] rb_out;

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [SEL_W-1:0]  ex_rd;
    logic [OP_W-1:0]   ex_op;

    // slave is the sequencer's view; master is the surrounding pipeline and bank
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_op,
        output issue_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rb_sel, rb_treg, rb_lreg, rb_in,
        input  rb_out,
        output ex_valid, ex_a, ex_b, ex_rd, ex_op,
        input  ex_ready
    );

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_op,
        input  issue_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rb_sel, rb_treg, rb_lreg, rb_in,
        output rb_out,
        input  ex_valid, ex_a, ex_b, ex_rd, ex_op,
        output ex_ready
    );
endinterface

// File: rtl/reg_port_sequencer_stall_limiter.sv
// Counts consecutive writeback cycles that stole the bank port from a pending
// read and refuses writebacks once the limit is reached so the read can go.
module stall_limiter
    import reg_port_sequencer_pkg::*;
#(
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic in_read_i,
    input  logic wb_valid_i,
    input  logic read_done_i,
    output logic wb_ready_o
);
    localparam int CNT_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;

    assign at_max     = (cnt_q == CNT_W'(STALL_MAX));
    assign wb_ready_o = en_i && !(in_read_i && at_max);

    always_comb begin
        cnt_d = cnt_q;
        if (read_done_i)
            cnt_d = '0;
        else if (in_read_i && wb_valid_i && wb_ready_o && !at_max)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reg_port_sequencer.sv
// Operand-fetch sequencer: reads two source registers through a single bank
// port shared with writeback (writeback wins, bounded by stall_limiter).
module reg_port_sequencer
    import reg_port_sequencer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int OP_W      = OP_W_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_port_sequencer_if.slave   seq_if
);
    seq_state_e        state_q, state_d;
    logic [SEL_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              active_q;

    logic              wb_ready, wb_fire, in_read, read_done;
    logic              issue_ready, ex_valid, rb_treg, rb_lreg;
    logic [SEL_W-1:0]  rb_sel;

    // Holds every handshake output low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active_q <= 1'b0;
        else        active_q <= 1'b1;
    end

    assign in_read = (state_q == READ_A) || (state_q == READ_B);
    assign wb_fire = seq_if.wb_valid && wb_ready;

    stall_limiter #(.STALL_MAX(STALL_MAX)) u_stall (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (active_q),
        .in_read_i   (in_read),
        .wb_valid_i  (seq_if.wb_valid),
        .read_done_i (read_done),
        .wb_ready_o  (wb_ready)
    );

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        read_done   = 1'b0;
        issue_ready = 1'b0;
        ex_valid    = 1'b0;
        rb_sel      = '0;
        rb_treg     = 1'b0;
        rb_lreg     = 1'b0;

        if (wb_fire) begin
            rb_sel  = seq_if.wb_rd;
            rb_lreg = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                issue_ready = active_q;
                if (active_q && seq_if.issue_valid) begin
                    rs1_d   = seq_if.issue_rs1;
                    rs2_d   = seq_if.issue_rs2;
                    rd_d    = seq_if.issue_rd;
                    op_d    = seq_if.issue_op;
                    state_d = READ_A;
                end
            end
            READ_A: if (!wb_fire) begin
                rb_sel    = rs1_q;
                rb_treg   = 1'b1;
                read_done = 1'b1;
                a_d       = seq_if.rb_out;
                if (rs1_q == rs2_q) begin
                    b_d     = seq_if.rb_out;
                    state_d = OUT;
                end else begin
                    state_d = READ_B;
                end
            end
            READ_B: if (!wb_fire) begin
                rb_sel    = rs2_q;
                rb_treg   = 1'b1;
                read_done = 1'b1;
                b_d       = seq_if.rb_out;
                state_d   = OUT;
            end
            OUT: begin
                ex_valid = 1'b1;
                if (seq_if.ex_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign seq_if.issue_ready = issue_ready;
    assign seq_if.wb_ready    = wb_ready;
    assign seq_if.rb_sel      = rb_sel;
    assign seq_if.rb_treg     = rb_treg;
    assign seq_if.rb_lreg     = rb_lreg;
    assign seq_if.rb_in       = active_q ? seq_if.wb_data : '0;
    assign seq_if.ex_valid    = ex_valid;
    assign seq_if.ex_a        = a_q;
    assign seq_if.ex_b        = b_q;
    assign seq_if.ex_rd       = rd_q;
    assign seq_if.ex_op       = op_q;
endmodule

// File: tb/tb_reg_port_sequencer.sv
// Randomized bench for reg_port_sequencer against a transaction-level model.
module tb_reg_port_sequencer;
    localparam int STALL_MAX = 3;
    localparam int NPAT      = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_port_sequencer_if bif ();

    reg_port_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bif)
    );

    // register bank environment
    logic [15:0] bank [8];
    always @(posedge clk) if (bif.rb_lreg) bank[bif.rb_sel] <= bif.rb_in;
    assign bif.rb_out = bif.rb_treg ? bank[bif.rb_sel] : 16'h0;

    logic [15:0] ref_mem [8];
    logic        pv   [NPAT];
    logic [2:0]  prd  [NPAT];
    logic [15:0] pdat [NPAT];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < NPAT; i++) begin
            pv[i] = 1'b0; prd[i] = 3'd0; pdat[i] = 16'h0;
        end
    endtask

    task automatic idle_inputs();
        bif.issue_valid = 1'b0;
        bif.issue_rs1 = 3'd0; bif.issue_rs2 = 3'd0; bif.issue_rd = 3'd0; bif.issue_op = 4'd0;
        bif.wb_valid = 1'b0; bif.wb_rd = 3'd0; bif.wb_data = 16'h0;
        bif.ex_ready = 1'b0;
    endtask

    task automatic wr_idle(input logic [2:0] r, input logic [15:0] d);
        @(posedge clk); #1;
        idle_inputs();
        bif.wb_valid = 1'b1; bif.wb_rd = r; bif.wb_data = d;
        @(negedge clk);
        chk("pre_wb_ready", 32'(bif.wb_ready), 32'd1);
        chk("pre_lreg", 32'(bif.rb_lreg), 32'd1);
        chk("pre_sel", 32'(bif.rb_sel), 32'(r));
        chk("pre_rb_in", 32'(bif.rb_in), 32'(d));
        ref_mem[r] = d;
    endtask

    // One issue, with writeback pattern pv/prd/pdat indexed from the accept cycle.
    task automatic run_txn(input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic [3:0] op, input int hold);
        logic [15:0] m [8];
        logic        ewr [NPAT];
        logic [15:0] ea, eb;
        int ph, st, L, H;
        for (int r = 0; r < 8; r++) m[r] = ref_mem[r];
        for (int k = 0; k < NPAT; k++) ewr[k] = 1'b1;
        ea = 16'h0; eb = 16'h0; ph = 0; st = 0; L = NPAT; H = NPAT - 1;

        // model: writeback owns the port, except after STALL_MAX back-to-back steals
        for (int k = 0; k < NPAT; k++) begin
            if (ph == 2 && k > H) break;
            if (k == 0 || ph == 2) begin
                if (pv[k]) m[prd[k]] = pdat[k];
            end else begin
                ewr[k] = (st < STALL_MAX);
                if (pv[k] && ewr[k]) begin
                    m[prd[k]] = pdat[k];
                    st++;
                end else if (ph == 0) begin
                    ea = m[rs1];
                    st = 0;
                    if (rs1 == rs2) begin eb = ea; ph = 2; L = k + 1; H = L + hold; end
                    else ph = 1;
                end else begin
                    eb = m[rs2];
                    ph = 2; L = k + 1; H = L + hold;
                end
            end
        end
        if (ph != 2) begin
            chk("model_done", 32'(ph), 32'd2);
            H = 10;
        end

        for (int k = 0; k <= H; k++) begin
            @(posedge clk); #1;
            bif.issue_valid = (k == 0);
            bif.issue_rs1 = (k == 0) ? rs1 : 3'($urandom_range(7));
            bif.issue_rs2 = (k == 0) ? rs2 : 3'($urandom_range(7));
            bif.issue_rd  = rd;
            bif.issue_op  = op;
            bif.wb_valid  = pv[k]; bif.wb_rd = prd[k]; bif.wb_data = pdat[k];
            bif.ex_ready  = (k < L) ? 1'($urandom_range(1)) : (k == H);
            @(negedge clk);
            chk("issue_ready", 32'(bif.issue_ready), 32'(k == 0));
            chk("wb_ready", 32'(bif.wb_ready), 32'(ewr[k]));
            chk("lreg", 32'(bif.rb_lreg), 32'(pv[k] && ewr[k]));
            chk("rb_excl", 32'(bif.rb_lreg && bif.rb_treg), 32'd0);
            chk("ex_valid", 32'(bif.ex_valid), 32'(k >= L));
            if (k >= L) begin
                chk("ex_a", 32'(bif.ex_a), 32'(ea));
                chk("ex_b", 32'(bif.ex_b), 32'(eb));
                chk("ex_rd", 32'(bif.ex_rd), 32'(rd));
                chk("ex_op", 32'(bif.ex_op), 32'(op));
            end
        end
        for (int r = 0; r < 8; r++) ref_mem[r] = m[r];

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("idle_ready", 32'(bif.issue_ready), 32'd1);
        chk("idle_ex_valid", 32'(bif.ex_valid), 32'd0);
        chk("idle_rb", 32'({bif.rb_sel, bif.rb_treg, bif.rb_lreg}), 32'd0);
        for (int r = 0; r < 8; r++) chk($sformatf("bank%0d", r), 32'(bank[r]), 32'(ref_mem[r]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue_ready"}, 32'(bif.issue_ready), 32'd0);
        chk({tag, "_wb_ready"}, 32'(bif.wb_ready), 32'd0);
        chk({tag, "_ex_valid"}, 32'(bif.ex_valid), 32'd0);
        chk({tag, "_rb"}, 32'({bif.rb_sel, bif.rb_treg, bif.rb_lreg}), 32'd0);
        chk({tag, "_rb_in"}, 32'(bif.rb_in), 32'd0);
        chk({tag, "_ex_ab"}, {bif.ex_a, bif.ex_b}, 32'd0);
        chk({tag, "_ex_rd_op"}, 32'({bif.ex_rd, bif.ex_op}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        bif.wb_valid = 1'b1; bif.wb_data = 16'hFFFF; bif.wb_rd = 3'd5;
        bif.issue_valid = 1'b1; bif.issue_rs1 = 3'd3; bif.issue_op = 4'hF;
        #23;
        chk_all_zero("rst");
        idle_inputs();
        @(negedge clk); rst_n = 1'b1;

        // preload bank through idle writebacks
        for (int r = 0; r < 8; r++) wr_idle(3'(r), 16'($urandom));
        wr_idle(3'd2, 16'h1234);
        wr_idle(3'd5, 16'h00FF);
        wr_idle(3'd4, 16'hA5A5);

        clear_pat();
        run_txn(3'd2, 3'd5, 3'd7, 4'h3, 0);
        run_txn(3'd4, 3'd4, 3'd1, 4'h9, 0);

        // writeback to the source register during READ_A
        clear_pat();
        pv[1] = 1'b1; prd[1] = 3'd2; pdat[1] = 16'hBEEF;
        run_txn(3'd2, 3'd5, 3'd6, 4'h1, 0);

        // writeback held during READ_A until the port is forced to the read
        clear_pat();
        for (int k = 1; k <= 4; k++) begin pv[k] = 1'b1; prd[k] = 3'd6; pdat[k] = 16'(16'h1000 + k); end
        run_txn(3'd2, 3'd5, 3'd0, 4'h2, 0);

        // consumer stalls while sources are overwritten
        clear_pat();
        for (int k = 3; k <= 8; k++) begin pv[k] = 1'b1; prd[k] = 3'd2; pdat[k] = 16'($urandom); end
        run_txn(3'd2, 3'd5, 3'd3, 4'hC, 5);

        // reset during READ_B
        @(posedge clk); #1;
        idle_inputs();
        bif.issue_valid = 1'b1; bif.issue_rs1 = 3'd1; bif.issue_rs2 = 3'd3; bif.issue_rd = 3'd4; bif.issue_op = 4'h7;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        bif.wb_valid = 1'b1; bif.wb_rd = 3'd6; bif.wb_data = 16'h5A5A;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_rst_ready", 32'(bif.issue_ready), 32'd1);
            chk("post_rst_ex_valid", 32'(bif.ex_valid), 32'd0);
        end

        // randomized transactions with random writeback traffic
        for (int t = 0; t < 30; t++) begin
            logic [2:0] a, b;
            clear_pat();
            for (int k = 0; k < NPAT; k++) begin
                pv[k]   = ($urandom_range(99) < 50);
                prd[k]  = 3'($urandom_range(7));
                pdat[k] = 16'($urandom);
            end
            a = 3'($urandom_range(7));
            b = (t % 4 == 0) ? a : 3'($urandom_range(7));
            run_txn(a, b, 3'($urandom_range(7)), 4'($urandom_range(15)), $urandom_range(3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
